// File: rtl/fifo_drain_serializer.sv
// Pops words from a fall-ahead FIFO and streams them out as SLICE-bit slices on valid/ready.
// Optional `SERIALIZER_PARITY_EN adds out_parity_o (XOR of the whole loaded word).
module fifo_drain_serializer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SLICE       = 2,
    parameter int unsigned SLICE_CNT_l = 2,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo_dout_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic [SLICE-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             busy_o,
    output logic [15:0]      words_sent_o
`ifdef SERIALIZER_PARITY_EN
    ,
    output logic             out_parity_o
`endif
);

    localparam int unsigned Ratio = WIDTH / SLICE;
    // A one-slice word still needs a legal counter vector.
    localparam int unsigned CntW = (SLICE_CNT_l > 0) ? SLICE_CNT_l : 1;
    localparam logic [CntW-1:0] CntPreLast = CntW'(Ratio - 2);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [CntW-1:0]  cnt_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic [15:0]      words_q;
    logic             handshake;
    logic             pop;

    assign handshake = valid_q & out_ready_i;
    assign pop = ~reset & ~fifo_empty_i &
                 ((state_q == StIdle) | ((state_q == StShift) & handshake & last_q));

    // The current slice always sits at the output end of the shift register.
    if (MSB_FIRST) begin : g_msb
        assign shift_next = shift_q << SLICE;
        assign out_data_o = shift_q[WIDTH-1 -: SLICE];
    end else begin : g_lsb
        assign shift_next = shift_q >> SLICE;
        assign out_data_o = shift_q[SLICE-1:0];
    end

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^fifo_dout_i;
        end else if (handshake && last_q) begin
            parity_q <= 1'b0;
        end
    end

    assign out_parity_o = parity_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            words_q <= '0;
        end else begin
            if (handshake && last_q) begin
                words_q <= words_q + 16'd1;
            end
            if (pop) begin
                state_q <= StShift;
                shift_q <= fifo_dout_i;
                cnt_q   <= '0;
                valid_q <= 1'b1;
                last_q  <= (Ratio == 1);
                busy_q  <= 1'b1;
            end else if ((state_q == StShift) && handshake) begin
                if (last_q) begin
                    state_q <= StIdle;
                    shift_q <= '0;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    shift_q <= shift_next;
                    cnt_q   <= cnt_q + CntW'(1);
                    last_q  <= (cnt_q == CntPreLast);
                end
            end
        end
    end

    assign fifo_rd_o    = pop;
    assign out_valid_o  = valid_q;
    assign out_last_o   = last_q;
    assign busy_o       = busy_q;
    assign words_sent_o = words_q;

    a_no_underflow_pop: assert property (@(posedge clock) disable iff (reset)
        fifo_empty_i |-> !fifo_rd_o);

    a_hold_without_handshake: assert property (@(posedge clock) disable iff (reset)
        (out_valid_o && !out_ready_i) |=>
            (out_valid_o && $stable(out_data_o) && $stable(out_last_o)));

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: directed scenarios plus random traffic checked against a
// queue-based model of the slice stream and the FIFO.
module tb_fifo_drain_serializer;

    localparam int WIDTH       = 8;
    localparam int SLICE       = 2;
    localparam int SLICE_CNT_l = 2;
    localparam bit MSB_FIRST   = 1'b1;
    localparam int RATIO       = WIDTH / SLICE;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic             out_ready = 1'b0;
    logic             fifo_rd_o;
    logic [SLICE-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_last_o;
    logic             busy_o;
    logic [15:0]      words_sent_o;
`ifdef SERIALIZER_PARITY_EN
    logic             out_parity_o;
    logic             par_acc[$];
`endif

    always #5 clock = ~clock;

    fifo_drain_serializer #(
        .WIDTH       (WIDTH),
        .SLICE       (SLICE),
        .SLICE_CNT_l (SLICE_CNT_l),
        .MSB_FIRST   (MSB_FIRST)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .words_sent_o (words_sent_o)
`ifdef SERIALIZER_PARITY_EN
        ,
        .out_parity_o (out_parity_o)
`endif
    );

    int unsigned      n_total = 0;
    int unsigned      n_bad = 0;
    logic [WIDTH-1:0] fq[$];    // FIFO contents, head at index 0
    logic [SLICE-1:0] cur[$];   // slices of the current word still to be accepted
    logic             cur_par = 1'b0;
    logic [15:0]      ws_exp = '0;
    logic [SLICE-1:0] acc[$];   // slices the DUT handed over

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_model(input logic [WIDTH-1:0] w);
        int sh;
        cur.delete();
        for (int k = 0; k < RATIO; k++) begin
            sh = MSB_FIRST ? (WIDTH - (k + 1) * SLICE) : (k * SLICE);
            cur.push_back(SLICE'(w >> sh));
        end
        cur_par = ^w;
    endtask

    task automatic cycle(input logic rst, input logic rdy);
        logic             exp_valid;
        logic             exp_rd;
        logic             got_rd;
        logic [WIDTH-1:0] head;
        @(negedge clock);
        reset      = rst;
        out_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
        head       = fifo_dout;
        #1;
        exp_valid = (cur.size() != 0);
        exp_rd    = !rst && (fq.size() != 0) && (!exp_valid || (rdy && cur.size() == 1));
        check_eq("out_valid", 32'(out_valid_o), 32'(exp_valid));
        check_eq("busy", 32'(busy_o), 32'(exp_valid));
        check_eq("out_last", 32'(out_last_o), 32'(exp_valid && cur.size() == 1));
        if (exp_valid) check_eq("out_data", 32'(out_data_o), 32'(cur[0]));
        check_eq("fifo_rd", 32'(fifo_rd_o), 32'(exp_rd));
        check_eq("words_sent", 32'(words_sent_o), 32'(ws_exp));
`ifdef SERIALIZER_PARITY_EN
        check_eq("out_parity", 32'(out_parity_o), 32'(exp_valid ? cur_par : 1'b0));
        if (out_valid_o && rdy) par_acc.push_back(out_parity_o);
`endif
        if (out_valid_o && rdy) acc.push_back(out_data_o);
        got_rd = fifo_rd_o;
        @(posedge clock);
        if (got_rd && fq.size() != 0) void'(fq.pop_front());
        if (rst) begin
            cur.delete();
            ws_exp = '0;
        end else begin
            if (exp_valid && rdy) begin
                if (cur.size() == 1) ws_exp = ws_exp + 16'd1;
                void'(cur.pop_front());
            end
            if (exp_rd) load_model(head);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((cur.size() != 0 || fq.size() != 0) && n < 100) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        cycle(1'b0, 1'b1);
        check_eq({tag, "_drained"}, 32'(n < 100), 32'd1);
        #2;
    endtask

    logic [SLICE-1:0] exp_b4_1e[8] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};

    task automatic check_acc(input string tag, input int first, input int cnt);
        check_eq({tag, "_count"}, 32'(acc.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            check_eq($sformatf("%s_slice%0d", tag, i),
                     (i < acc.size()) ? 32'(acc[i]) : 32'hDEAD, 32'(exp_b4_1e[first + i]));
        end
    endtask

    initial begin
        // Reset held with a word waiting, then that word drained
        fq.push_back(8'hB4);
        repeat (3) cycle(1'b1, 1'b1);
        acc.delete();
        drain("t2");
        check_acc("t2", 0, 4);
        check_eq("t2_words", 32'(words_sent_o), 32'd1);
        check_eq("t2_idle", 32'(out_valid_o), 32'd0);

        // Two words back to back
        repeat (2) cycle(1'b1, 1'b0);
        fq.push_back(8'hB4);
        fq.push_back(8'h1E);
        acc.delete();
        drain("t3");
        check_acc("t3", 0, 8);
        check_eq("t3_words", 32'(words_sent_o), 32'd2);

        // Backpressure mid-word
        repeat (2) cycle(1'b1, 1'b0);
        fq.push_back(8'hB4);
        acc.delete();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0);
        drain("t4");
        check_acc("t4", 0, 4);

        // Reset after the second slice; next word restarts at slice 0
        repeat (2) cycle(1'b1, 1'b0);
        fq.push_back(8'hB4);
        fq.push_back(8'h1E);
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        acc.delete();
        drain("t5");
        check_acc("t5", 4, 4);
        check_eq("t5_words", 32'(words_sent_o), 32'd1);

`ifdef SERIALIZER_PARITY_EN
        repeat (2) cycle(1'b1, 1'b0);
        fq.push_back(8'hB4);
        fq.push_back(8'h07);
        par_acc.delete();
        drain("t6");
        check_eq("t6_count", 32'(par_acc.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t6_parity%0d", i),
                     (i < par_acc.size()) ? 32'(par_acc[i]) : 32'hDEAD, 32'(i >= 4));
        end
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if (fq.size() < 8 && $urandom_range(0, 9) < 4) fq.push_back(WIDTH'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
